// File: rtl/w_ingress_ctrl.sv
// Write-side ingress of the async FIFO: a two-entry skid buffer feeding the
// pointer block / memory write port, plus registered fill level, almost-full
// flag and a sticky pointer-integrity error derived from the gray pointers.
module w_ingress_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  w_full,
  input  logic [ADDR_WIDTH:0]   w_ptr,
  input  logic [ADDR_WIDTH:0]   w_q2_r_ptr,
  output logic                  w_inc,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_almost_full,
  output logic                  w_ptr_err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  s_ready_q, s_ready_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  afull_q, afull_d;
  logic                  err_q, err_d;
  logic                  acc_s;
  logic                  inc_s;
  logic [PW-1:0]         diff_s;

  // Skid-buffer occupancy FSM, entry steering and registered-ready lookahead.
  // The write strobe is gated by reset so a buffered word never escapes
  // during the cycle in which reset is being applied.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    acc_s   = s_valid & s_ready_q;
    inc_s   = w_rst_n & (state_q != ST_EMPTY) & ~w_full;
    case (state_q)
      ST_EMPTY: begin
        if (acc_s) begin
          state_d = ST_ONE;
          head_d  = s_data;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (acc_s && inc_s) begin
          head_d = s_data;
        end else if (acc_s) begin
          state_d = ST_TWO;
          tail_d  = s_data;
        end else if (inc_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (inc_s) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    s_ready_d = (state_d != ST_TWO);
  end

  // Occupancy from the binary pointer difference; modulo width handles the wrap.
  always_comb begin
    diff_s  = gray2bin(w_ptr) - gray2bin(w_q2_r_ptr);
    level_d = diff_s;
    afull_d = (diff_s >= AF_TH);
    err_d   = err_q | (diff_s > DEPTH);
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q   <= ST_EMPTY;
      head_q    <= {DATA_WIDTH{1'b0}};
      tail_q    <= {DATA_WIDTH{1'b0}};
      s_ready_q <= 1'b0;
      level_q   <= {PW{1'b0}};
      afull_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= s_ready_d;
      level_q   <= level_d;
      afull_q   <= afull_d;
      err_q     <= err_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign w_inc         = inc_s;
  assign w_data        = head_q;
  assign w_level       = level_q;
  assign w_almost_full = afull_q;
  assign w_ptr_err     = err_q;

endmodule

// File: tb/tb_w_ingress_ctrl.sv
// Self-checking bench for w_ingress_ctrl: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_w_ingress_ctrl;

  logic       w_clk = 1'b0;
  logic       w_rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       w_full;
  logic [4:0] w_ptr;
  logic [4:0] w_q2_r_ptr;
  logic       w_inc;
  logic [7:0] w_data;
  logic [4:0] w_level;
  logic       w_almost_full;
  logic       w_ptr_err;

  logic [4:0] w_bin_tb;
  logic [4:0] r_bin_tb;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] wlog[$];
  bit         just_rst = 1'b1;
  logic [4:0] m_level = 5'd0;
  bit         m_af = 1'b0;
  bit         m_err = 1'b0;
  bit         chk_en = 1'b0;

  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  assign w_ptr      = b2g(w_bin_tb);
  assign w_q2_r_ptr = b2g(r_bin_tb);

  w_ingress_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .w_full(w_full), .w_ptr(w_ptr), .w_q2_r_ptr(w_q2_r_ptr),
    .w_inc(w_inc), .w_data(w_data), .w_level(w_level),
    .w_almost_full(w_almost_full), .w_ptr_err(w_ptr_err)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit exp_ready();
    return !just_rst && (mq.size() < 2);
  endfunction

  function automatic bit exp_inc();
    return (w_rst_n === 1'b1) && (mq.size() > 0) && (w_full === 1'b0);
  endfunction

  // model update at the active edge, from the inputs the DUT sampled
  always @(posedge w_clk) begin
    logic [4:0] d;
    bit         inc;
    bit         rdy;
    if (w_rst_n === 1'b0) begin
      mq.delete();
      just_rst = 1'b1;
      m_level  = 5'd0;
      m_af     = 1'b0;
      m_err    = 1'b0;
    end else begin
      inc = exp_inc();
      rdy = exp_ready();
      d   = w_bin_tb - r_bin_tb;
      if (inc) void'(mq.pop_front());
      if (s_valid && rdy) mq.push_back(s_data);
      just_rst = 1'b0;
      m_level  = d;
      m_af     = (d >= 5'd12);
      m_err    = m_err || (d > 5'd16);
    end
  end

  // compare process on the inactive edge
  always @(negedge w_clk) begin
    if (chk_en) begin
      chk("s_ready", 32'(s_ready), 32'(exp_ready()));
      chk("w_inc", 32'(w_inc), 32'(exp_inc()));
      if (exp_inc() && mq.size() > 0) chk("w_data", 32'(w_data), 32'(mq[0]));
      chk("w_level", 32'(w_level), 32'(m_level));
      chk("w_almost_full", 32'(w_almost_full), 32'(m_af));
      chk("w_ptr_err", 32'(w_ptr_err), 32'(m_err));
      if (w_inc === 1'b1) wlog.push_back(w_data);
    end
  end

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    w_rst_n  = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    w_full   = 1'b0;
    w_bin_tb = 5'd0;
    r_bin_tb = 5'd0;
    tick();
    chk_en = 1'b1;
    tick();
    w_rst_n = 1'b1;

    // reset state
    @(negedge w_clk);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_inc", 32'(w_inc), 32'd0);
    chk("rst_level", 32'(w_level), 32'd0);
    chk("rst_err", 32'(w_ptr_err), 32'd0);
    tick();
    @(negedge w_clk);
    chk("ready_after_rst", 32'(s_ready), 32'd1);

    // streaming 0x01..0x10
    wlog.delete();
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      tick();
      if (i == 8) begin
        @(negedge w_clk);
        chk("stream_inc", 32'(w_inc), 32'd1);
        chk("stream_ready", 32'(s_ready), 32'd1);
      end
    end
    s_valid = 1'b0;
    tick();
    tick();
    chk("stream_cnt", 32'(wlog.size()), 32'd16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) chk("stream_seq", 32'(wlog[i]), 32'(i + 1));

    // backpressure via w_full
    wlog.delete();
    w_full  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA0;
    tick();
    s_data  = 8'hA1;
    tick();
    s_data  = 8'hA2;
    tick();
    tick();
    @(negedge w_clk);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_inc", 32'(w_inc), 32'd0);
    w_full  = 1'b0;
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("full_cnt", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("full_w0", 32'(wlog[0]), 32'hA0);
      chk("full_w1", 32'(wlog[1]), 32'hA1);
    end

    // level / almost-full / wrap / corruption
    w_bin_tb = 5'd12; r_bin_tb = 5'd0;
    tick();
    @(negedge w_clk);
    chk("lvl12", 32'(w_level), 32'd12);
    chk("af12", 32'(w_almost_full), 32'd1);
    r_bin_tb = 5'd1;
    tick();
    @(negedge w_clk);
    chk("lvl11", 32'(w_level), 32'd11);
    chk("af11", 32'(w_almost_full), 32'd0);
    w_bin_tb = 5'd1; r_bin_tb = 5'd30;
    tick();
    @(negedge w_clk);
    chk("lvl_wrap", 32'(w_level), 32'd3);
    w_bin_tb = 5'd16; r_bin_tb = 5'd0;
    tick();
    @(negedge w_clk);
    chk("lvl16", 32'(w_level), 32'd16);
    chk("err16", 32'(w_ptr_err), 32'd0);
    w_bin_tb = 5'd20;
    tick();
    @(negedge w_clk);
    chk("err20", 32'(w_ptr_err), 32'd1);
    w_bin_tb = 5'd3; r_bin_tb = 5'd1;
    tick();
    tick();
    @(negedge w_clk);
    chk("err_sticky", 32'(w_ptr_err), 32'd1);
    chk("lvl2", 32'(w_level), 32'd2);

    // reset while holding two words
    w_full  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hB0;
    tick();
    s_data  = 8'hB1;
    tick();
    s_valid = 1'b0;
    tick();
    wlog.delete();
    w_rst_n = 1'b0;
    w_full  = 1'b0;
    @(negedge w_clk);
    chk("rst_cycle_inc", 32'(w_inc), 32'd0);
    tick();
    w_rst_n = 1'b1;
    @(negedge w_clk);
    chk("post_rst_ready", 32'(s_ready), 32'd0);
    chk("post_rst_inc", 32'(w_inc), 32'd0);
    chk("post_rst_level", 32'(w_level), 32'd0);
    chk("post_rst_af", 32'(w_almost_full), 32'd0);
    chk("post_rst_err", 32'(w_ptr_err), 32'd0);
    tick();
    tick();
    tick();
    chk("post_rst_nowrite", 32'(wlog.size()), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] off;
      w_rst_n = ($urandom_range(0, 149) != 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      w_full  = ($urandom_range(0, 3) == 0);
      r_bin_tb = 5'($urandom);
      if ($urandom_range(0, 299) == 0) off = 5'($urandom_range(17, 31));
      else off = 5'($urandom_range(0, 16));
      w_bin_tb = r_bin_tb + off;
      tick();
    end
    w_rst_n = 1'b1;
    s_valid = 1'b0;
    w_full  = 1'b0;
    tick();
    tick();
    tick();
    chk("drained", 32'(mq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
